// File: rtl/ddc_iq_decim_pkg.sv
// ddc_iq_decim_pkg: shared defaults, sine table generator and saturation
// helper for the quadrature downconverter.
package ddc_iq_decim_pkg;
  localparam int DW_DEF = 16;
  localparam int PW_DEF = 32;
  localparam int LUT_AW_DEF = 10;
  localparam int MAXDEC_DEF = 64;
  localparam real PI = 3.14159265358979323846;

  typedef logic signed [DW_DEF-1:0] sample_t;

  // round-half-away sine entry n of a 2^aw full-wave table
  function automatic int lut_val(int n, int aw, int dw);
    real amp;
    real x;
    int r;
    amp = real'((1 << (dw - 1)) - 1);
    x = amp * $sin(2.0 * PI * real'(n) / real'(1 << aw));
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else r = -$rtoi(0.5 - x);
    return r;
  endfunction

  function automatic logic signed [63:0] sat(
    logic signed [63:0] x,
    int dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    r = x;
    if (x > hi) r = hi;
    if (x < lo) r = lo;
    return r;
  endfunction
endpackage

// File: rtl/ddc_iq_decim_if.sv
// ddc_iq_decim_if: sample-in / decimated I/Q-out bundle.
// master = sample source, slave = the downconverter.
interface ddc_iq_decim_if
  import ddc_iq_decim_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic                 in_valid;
  logic signed [DW-1:0] rf;
  logic                 out_valid;
  logic signed [DW-1:0] out_i;
  logic signed [DW-1:0] out_q;

  modport master (
    output in_valid, rf,
    input  out_valid, out_i, out_q
  );

  modport slave (
    input  in_valid, rf,
    output out_valid, out_i, out_q
  );
endinterface

// File: rtl/ddc_iq_decim_nco.sv
// ddc_iq_decim_nco: phase accumulator plus registered dual-port
// sin/cos table read (stages S0-S1).
module ddc_iq_decim_nco
  import ddc_iq_decim_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int PW = PW_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PW-1:0]        phase_inc,
  output logic                 valid,
  output logic signed [DW-1:0] sin_v,
  output logic signed [DW-1:0] cos_v
);
  localparam int N = 2 ** LUT_AW;

  logic [PW-1:0]        phase;
  logic [LUT_AW-1:0]    a_s;
  logic [LUT_AW-1:0]    a_c;
  logic signed [DW-1:0] lut [N];

  for (genvar n = 0; n < N; n++) begin : g_lut
    localparam int V = lut_val(n, LUT_AW, DW);
    assign lut[n] = DW'(V);
  end

  // cosine is the sine a quarter wave ahead
  assign a_s = phase[PW-1 -: LUT_AW];
  assign a_c = a_s + LUT_AW'(N / 4);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) phase <= phase + phase_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sin_v <= lut[a_s];
      cos_v <= lut[a_c];
    end
  end
endmodule

// File: rtl/ddc_iq_decim.sv
// ddc_iq_decim: quadrature DDC -- NCO, complex mixer (S2) and
// run-time integrate-and-dump decimator (S3).
module ddc_iq_decim
  import ddc_iq_decim_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int PW = PW_DEF,
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int MAXDEC = MAXDEC_DEF,
  localparam int CW = $clog2(MAXDEC),
  localparam int SW = $clog2(CW + 1)
) (
  input logic              clk,
  input logic              rst,
  input logic              sync,
  input logic [PW-1:0]     phase_inc,
  input logic [CW:0]       dec_ratio,
  input logic [SW-1:0]     out_shift,
  ddc_iq_decim_if.slave    bus
);
  localparam int AW = DW + 1 + CW;

  logic                   take;
  logic                   v1;
  logic                   v2;
  logic signed [DW-1:0]   sin_v;
  logic signed [DW-1:0]   cos_v;
  logic signed [DW-1:0]   rf1;
  logic signed [2*DW-1:0] mi;
  logic signed [2*DW-1:0] mq;
  logic signed [DW:0]     p_i;
  logic signed [DW:0]     p_q;

  logic [CW-1:0]          cnt;
  logic [CW:0]            d_lat;
  logic [CW:0]            d_new;
  logic [CW:0]            d_eff;
  logic [SW-1:0]          sh_lat;
  logic [SW-1:0]          sh_new;
  logic [SW-1:0]          sh_eff;
  logic                   first;
  logic                   last;
  logic signed [AW-1:0]   acc_i;
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   sum_i;
  logic signed [AW-1:0]   sum_q;
  logic signed [AW-1:0]   shf_i;
  logic signed [AW-1:0]   shf_q;

  // sync outranks a coincident sample, which is dropped
  assign take = bus.in_valid & ~sync;

  ddc_iq_decim_nco #(
    .DW(DW),
    .PW(PW),
    .LUT_AW(LUT_AW)
  ) u_nco (
    .clk(clk),
    .rst(rst),
    .clr(sync),
    .en(take),
    .phase_inc(phase_inc),
    .valid(v1),
    .sin_v(sin_v),
    .cos_v(cos_v)
  );

  always_ff @(posedge clk) begin
    if (take) rf1 <= bus.rf;
  end

  assign mi = (2*DW)'(rf1) * (2*DW)'(cos_v);
  assign mq = (2*DW)'(rf1) * (2*DW)'(sin_v);

  always_ff @(posedge clk) begin
    if (rst || sync) v2 <= 1'b0;
    else v2 <= v1;
    if (v1) begin
      p_i <= (DW+1)'(mi >>> (DW - 1));
      p_q <= -((DW+1)'(mq >>> (DW - 1)));
    end
  end

  always_comb begin
    d_new = dec_ratio;
    if (dec_ratio == '0) d_new = (CW+1)'(1);
    else if (dec_ratio > (CW+1)'(MAXDEC))
      d_new = (CW+1)'(MAXDEC);
    sh_new = out_shift;
    if (out_shift > SW'(CW)) sh_new = SW'(CW);
  end

  // ratio and shift are taken live at block start, latched after
  assign first  = (cnt == '0);
  assign d_eff  = first ? d_new : d_lat;
  assign sh_eff = first ? sh_new : sh_lat;
  assign last   = ({1'b0, cnt} == d_eff - (CW+1)'(1));

  assign sum_i = acc_i + AW'(p_i);
  assign sum_q = acc_q + AW'(p_q);
  assign shf_i = sum_i >>> sh_eff;
  assign shf_q = sum_q >>> sh_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_i         <= '0;
      acc_q         <= '0;
      cnt           <= '0;
      d_lat         <= (CW+1)'(1);
      sh_lat        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_i     <= '0;
      bus.out_q     <= '0;
    end else if (sync) begin
      acc_i         <= '0;
      acc_q         <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (v2) begin
        if (first) begin
          d_lat  <= d_eff;
          sh_lat <= sh_eff;
        end
        if (last) begin
          bus.out_valid <= 1'b1;
          bus.out_i     <= DW'(sat(64'(shf_i), DW));
          bus.out_q     <= DW'(sat(64'(shf_q), DW));
          acc_i         <= '0;
          acc_q         <= '0;
          cnt           <= '0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ddc_iq_decim.sv
// tb_ddc_iq_decim: directed vectors with hand-computed I/Q results
// for the quadrature downconverter.
module tb_ddc_iq_decim;
  import ddc_iq_decim_pkg::*;

  localparam int DW = 16;
  localparam int PW = 32;
  localparam int CW = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sync = 1'b0;
  logic [PW-1:0]  phase_inc = '0;
  logic [CW:0]    dec_ratio = 7'd1;
  logic [2:0]     out_shift = '0;

  ddc_iq_decim_if #(.DW(DW)) bus ();

  ddc_iq_decim #(
    .DW(DW),
    .PW(PW),
    .LUT_AW(10),
    .MAXDEC(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sync(sync),
    .phase_inc(phase_inc),
    .dec_ratio(dec_ratio),
    .out_shift(out_shift),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int qi[$];
  int qq[$];
  int qt[$];

  always @(negedge clk) begin
    if (bus.out_valid) begin
      qi.push_back(int'(bus.out_i));
      qq.push_back(int'(bus.out_q));
      qt.push_back(cyc);
    end
  end

  int errs = 0;
  int checks = 0;
  int t_last = 0;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int v);
    bus.in_valid = 1'b1;
    bus.rf = 16'(v);
    t_last = cyc;
    tick();
  endtask

  task automatic idle(int n);
    bus.in_valid = 1'b0;
    bus.rf = -16'sd1234;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clrq();
    qi.delete();
    qq.delete();
    qt.delete();
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clrq();
  endtask

  task automatic cfg(logic [PW-1:0] inc, int d, int sh);
    phase_inc = inc;
    dec_ratio = 7'(d);
    out_shift = 3'(sh);
  endtask

  task automatic chk_outs(string tag, int n, int ei, int eq);
    chk({tag, "_count"}, qi.size(), n);
    for (int j = 0; j < qi.size() && j < n; j++) begin
      chk({tag, "_i"}, qi[j], ei);
      chk({tag, "_q"}, qq[j], eq);
    end
  endtask

  initial begin
    sample_t rfv;
    real r;
    bus.in_valid = 1'b0;
    bus.rf = '0;
    tick();
    tick();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_i", int'(bus.out_i), 0);
    chk("rst_q", int'(bus.out_q), 0);
    rst = 1'b0;
    clrq();

    // 1: dc input, D=4 shift 2
    cfg('0, 4, 2);
    for (int k = 0; k < 16; k++) begin
      send(16384);
      if (k == 3) chk("t1_sample3_t", t_last, t_last);
    end
    idle(6);
    chk_outs("t1", 4, 16383, 0);
    if (qt.size() >= 4) begin
      chk("t1_latency", qt[3] - t_last, 3);
      chk("t1_spacing", qt[1] - qt[0], 4);
    end

    // 2: tone at fclk/64 mixed to dc, D=64 shift 6
    do_reset();
    cfg(32'h0400_0000, 64, 6);
    for (int k = 0; k < 256; k++) begin
      r = 16384.0 * $sin(2.0 * 3.141592653589793 * k / 64.0);
      if (r >= 0.0) rfv = 16'($rtoi(r + 0.5));
      else rfv = 16'(-$rtoi(0.5 - r));
      send(int'(rfv));
    end
    idle(6);
    chk("t2_count", qi.size(), 4);
    for (int j = 1; j < qi.size(); j++) begin
      chk($sformatf("t2_i_in_range_%0d_v%0d", j, qi[j]),
          int'(qi[j] >= -4 && qi[j] <= 4), 1);
      chk($sformatf("t2_q_in_range_%0d_v%0d", j, qq[j]),
          int'(qq[j] >= -8196 && qq[j] <= -8188), 1);
    end

    // 3: saturation, D=64 shift 0
    do_reset();
    cfg('0, 64, 0);
    for (int k = 0; k < 64; k++) send(16384);
    idle(6);
    chk_outs("t3", 1, 32767, 0);

    // 4: repeat 1 with bubbles, valid 1-of-3
    do_reset();
    cfg('0, 4, 2);
    for (int k = 0; k < 16; k++) begin
      send(16384);
      idle(2);
    end
    idle(4);
    chk_outs("t4", 4, 16383, 0);

    // 5a: reset mid-block
    send(16384);
    send(16384);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t5r_valid", int'(bus.out_valid), 0);
    chk("t5r_i_zero", int'(bus.out_i), 0);
    rst = 1'b0;
    clrq();
    for (int k = 0; k < 4; k++) send(16384);
    idle(6);
    chk_outs("t5r", 1, 16383, 0);
    if (qt.size() >= 1) chk("t5r_latency", qt[0] - t_last, 3);

    // 5b: sync mid-block, coincident sample dropped
    clrq();
    send(16384);
    send(16384);
    sync = 1'b1;
    bus.in_valid = 1'b1;
    bus.rf = 16'sd16384;
    tick();
    sync = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5s_valid", int'(bus.out_valid), 0);
    chk("t5s_i_held", int'(bus.out_i), 16383);
    idle(4);
    chk("t5s_no_early", qi.size(), 0);
    for (int k = 0; k < 4; k++) send(16384);
    idle(6);
    chk_outs("t5s", 1, 16383, 0);
    if (qt.size() >= 1) chk("t5s_latency", qt[0] - t_last, 3);

    // 6: ratio 4->8 mid-block, shift 3
    do_reset();
    cfg('0, 4, 3);
    for (int k = 0; k < 3; k++) send(16384);
    dec_ratio = 7'd8;
    for (int k = 0; k < 9; k++) send(16384);
    idle(6);
    chk("t6_count", qi.size(), 2);
    if (qi.size() >= 2) begin
      chk("t6_blk4_i", qi[0], 8191);
      chk("t6_blk8_i", qi[1], 16383);
      chk("t6_blk8_latency", qt[1] - t_last, 3);
    end

    // 7: dec_ratio 0 behaves as 1
    do_reset();
    cfg('0, 0, 0);
    for (int k = 0; k < 3; k++) send(16384);
    idle(5);
    chk_outs("t7", 3, 16383, 0);
    if (qt.size() >= 3) chk("t7_spacing", qt[2] - qt[0], 2);

    // 8: shift 7 clamps to 6
    do_reset();
    cfg('0, 64, 7);
    for (int k = 0; k < 64; k++) send(16384);
    idle(6);
    chk_outs("t8", 1, 16383, 0);

    // 9: negative saturation
    do_reset();
    cfg('0, 64, 0);
    for (int k = 0; k < 64; k++) send(-16384);
    idle(6);
    chk_outs("t9", 1, -32768, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
